// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch -- instruction fetch unit with a DEPTH-entry prefetch queue.
//
// Holds the fetch PC, drives a combinational instruction-memory port, and
// buffers fetched {pc, instr[, exc]} entries so fetch keeps going while decode
// stalls. Any control-flow redirect flushes the queue and restarts fetch at
// the redirect target (jr > jump > branch priority).
//
// Optional feature (compile-time macro IFU_ADEL_CHECK_EN):
//   When defined, every fetch address is checked for misalignment and for
//   lying outside [PC_LO, PC_HI]. A faulting fetch is queued with exc=1 and
//   instr=0 without waiting for imem_ready. When undefined, out_exc is 0 and
//   no exception state is kept.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   imem_addr           fetch address (= fetch PC)
//   imem_rdata/ready    instruction word for imem_addr, valid same cycle
//   redirect_* / *_addr control-flow redirect requests and targets
//   out_valid/ready     queue head handshake towards the F/D register
//   out_pc/instr/exc    head entry contents (registered, no bypass)
//   count               queue occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_ready,
    input  logic                       redirect_jr,
    input  logic [31:0]                jr_addr,
    input  logic                       redirect_jump,
    input  logic [31:0]                jump_addr,
    input  logic                       redirect_branch,
    input  logic [31:0]                branch_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_exc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // State
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_pc_d    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
`ifdef IFU_ADEL_CHECK_EN
    logic          mem_exc_q   [DEPTH];
    logic          mem_exc_d   [DEPTH];
`endif

    logic redir, pop, push, exc, fetch_src;

    // Address-error check on the current fetch PC.
`ifdef IFU_ADEL_CHECK_EN
    assign exc = (fetch_pc_q[1:0] != 2'b00) | (fetch_pc_q < PC_LO) | (fetch_pc_q > PC_HI);
`else
    assign exc = 1'b0;
`endif

    // A faulting fetch never reaches memory, so it need not wait for ready.
    assign fetch_src = imem_ready | exc;
    assign redir     = redirect_jr | redirect_jump | redirect_branch;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full queue may still accept a new entry in the same cycle it pops.
    assign push      = fetch_src & ~redir & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
`ifdef IFU_ADEL_CHECK_EN
        mem_exc_d   = mem_exc_q;
`endif
        if (redir) begin
            // Flush; any pop in this cycle is discarded by the consumer.
            if (redirect_jr)        fetch_pc_d = jr_addr;
            else if (redirect_jump) fetch_pc_d = jump_addr;
            else                    fetch_pc_d = branch_addr;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]    = fetch_pc_q;
                mem_instr_d[wr_ptr_q] = exc ? 32'h0 : imem_rdata;
`ifdef IFU_ADEL_CHECK_EN
                mem_exc_d[wr_ptr_q]   = exc;
`endif
                wr_ptr_d   = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
                fetch_pc_d = fetch_pc_q + 32'd4; // wraps modulo 2^32
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_pc_q    <= '{default: '0};
            mem_instr_q <= '{default: '0};
`ifdef IFU_ADEL_CHECK_EN
            mem_exc_q   <= '{default: 1'b0};
`endif
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
`ifdef IFU_ADEL_CHECK_EN
            mem_exc_q   <= mem_exc_d;
`endif
        end
    end

    assign imem_addr = fetch_pc_q;
    assign count     = count_q;
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_instr = mem_instr_q[rd_ptr_q];
`ifdef IFU_ADEL_CHECK_EN
    assign out_exc   = mem_exc_q[rd_ptr_q];
`else
    assign out_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: a queue-level reference model tracks fetch PC and
// queued entries; a negedge process compares every cycle, and directed steps
// add literal checks from the test plan.
module tb_ifu_prefetch;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] PC_LO = 32'h0000_3000;
    localparam logic [31:0] PC_HI = 32'h0000_6FFC;
`ifdef IFU_ADEL_CHECK_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic        redirect_jr, redirect_jump, redirect_branch;
    logic [31:0] jr_addr, jump_addr, branch_addr;
    logic        out_valid, out_ready, out_exc;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic exc_of(input logic [31:0] a);
        return EXC_EN && ((a[1:0] != 2'b00) || (a < PC_LO) || (a > PC_HI));
    endfunction

    assign imem_rdata = rfn(imem_addr);

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .PC_LO(PC_LO), .PC_HI(PC_HI)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .redirect_jr(redirect_jr), .jr_addr(jr_addr),
        .redirect_jump(redirect_jump), .jump_addr(jump_addr),
        .redirect_branch(redirect_branch), .branch_addr(branch_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
        .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries plus the fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    bit          started = 1'b0;

    always @(posedge clk) begin
        logic e;
        started = 1'b1;
        if (reset) begin
            mpc = RESET_PC;
            mq.delete();
        end else if (redirect_jr || redirect_jump || redirect_branch) begin
            mq.delete();
            mpc = redirect_jr ? jr_addr : (redirect_jump ? jump_addr : branch_addr);
        end else begin
            e = exc_of(mpc);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if ((imem_ready || e) && mq.size() < DEPTH) begin
                mq.push_back('{pc: mpc, instr: (e ? 32'h0 : rfn(mpc)), exc: e});
                mpc = mpc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("m_addr", imem_addr, mpc);
            if (mq.size() != 0) begin
                chk("m_pc", out_pc, mq[0].pc);
                chk("m_instr", out_instr, mq[0].instr);
                chk("m_exc", 32'(out_exc), 32'(mq[0].exc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; out_ready = 1'b0;
        redirect_jr = 1'b0; redirect_jump = 1'b0; redirect_branch = 1'b0;
        jr_addr = '0; jump_addr = '0; branch_addr = '0;
        step(2);
        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_exc", 32'(out_exc), 0);
        chk("rst_addr", imem_addr, 32'h3000);

        // 1: streaming
        reset = 1'b0; imem_ready = 1'b1; out_ready = 1'b1;
        step(1);
        chk("t1_pc0", out_pc, 32'h3000);
        chk("t1_instr0", out_instr, rfn(32'h3000));
        step(1);
        chk("t1_pc1", out_pc, 32'h3004);
        chk("t1_cnt", 32'(count), 1);
        step(1);
        chk("t1_pc2", out_pc, 32'h3008);

        // 2: fill then drain
        do_reset();
        out_ready = 1'b0;
        step(6);
        chk("t2_full", 32'(count), 4);
        chk("t2_addr", imem_addr, 32'h3010);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t2_drain", out_pc, 32'h3000 + 32'(4 * i));
            step(1);
        end

        // 3: concurrent redirects
        do_reset();
        out_ready = 1'b0;
        step(3);
        chk("t3_cnt3", 32'(count), 3);
        redirect_jump = 1'b1; jump_addr = 32'h3100;
        redirect_branch = 1'b1; branch_addr = 32'h3200;
        step(1);
        chk("t3_cnt", 32'(count), 0);
        chk("t3_valid", 32'(out_valid), 0);
        chk("t3_addr", imem_addr, 32'h3100);
        redirect_jump = 1'b0; redirect_branch = 1'b0;
        step(3);
        redirect_jr = 1'b1; jr_addr = 32'h3300;
        redirect_jump = 1'b1; redirect_branch = 1'b1;
        step(1);
        chk("t3_jr_addr", imem_addr, 32'h3300);
        redirect_jr = 1'b0; redirect_jump = 1'b0; redirect_branch = 1'b0;

        // 4: imem_ready toggling
        out_ready = 1'b1;
        imem_ready = 1'b1; step(1); chk("t4_a1", imem_addr, 32'h3304);
        imem_ready = 1'b0; step(1); chk("t4_a2", imem_addr, 32'h3304);
        imem_ready = 1'b1; step(1); chk("t4_a3", imem_addr, 32'h3308);
        imem_ready = 1'b0; step(1); chk("t4_a4", imem_addr, 32'h3308);

        // 5: reset beats redirect while full
        imem_ready = 1'b1; out_ready = 1'b0;
        step(5);
        chk("t5_full", 32'(count), 4);
        reset = 1'b1; redirect_branch = 1'b1; branch_addr = 32'h3200;
        step(1);
        chk("t5_addr", imem_addr, 32'h3000);
        chk("t5_cnt", 32'(count), 0);
        chk("t5_pc", out_pc, 0);
        reset = 1'b0; redirect_branch = 1'b0;

        // 6: address-error entries
        redirect_jr = 1'b1; jr_addr = 32'h3002;
        step(1);
        redirect_jr = 1'b0;
        step(1);
        chk("t6_pc", out_pc, 32'h3002);
        chk("t6_exc", 32'(out_exc), 32'(EXC_EN));
        chk("t6_instr", out_instr, EXC_EN ? 32'h0 : rfn(32'h3002));
        redirect_jr = 1'b1; jr_addr = 32'h7000;
        step(1);
        redirect_jr = 1'b0;
        step(1);
        chk("t6_pc2", out_pc, 32'h7000);
        chk("t6_exc2", 32'(out_exc), 32'(EXC_EN));
        // Faulting fetches do not wait for imem_ready.
        imem_ready = 1'b0; out_ready = 1'b1;
        step(3);
        // Wrap of fetch_pc at the top of the address space.
        out_ready = 1'b1; imem_ready = 1'b1;
        redirect_branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step(1);
        redirect_branch = 1'b0;
        step(1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
